ssp_link: RTL

SSP_LINK -- requirements
Module: ssp_link

---
 rtl/ssp_link_pkg.sv | 14 +
 rtl/ssp_clk_gen.sv | 50 +++++
 rtl/ssp_link.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ssp_link_pkg.sv
// Shared defaults and types for the SSP link to the ARM.
package ssp_link_pkg;

    localparam int         DEF_CLK_DIV   = 4;
    localparam int         DEF_WORD_BITS = 8;
    localparam logic [7:0] IDLE_WORD     = 8'h00;

    // One-cycle strobes marking where ssp_clk changes level.
    typedef struct packed {
        logic fall;
        logic rise;
    } ssp_edge_t;

endpackage

// File: rtl/ssp_clk_gen.sv
// SSP bit-clock divider: free-running div_cnt, registered ssp_clk and
// edge-event strobes. The strobes are high in the cycle before the
// ssp_clk level change, so state updated on that clock edge lines up
// with the new ssp_clk level.
module ssp_clk_gen
    import ssp_link_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic      clk,
    input  logic      rst,
    output logic      ssp_clk,
    output ssp_edge_t strb
);

    localparam int            CW      = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST    = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF    = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] RISE_AT = CW'(CLK_DIV / 2 - 1);

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic          ssp_clk_q, ssp_clk_d;

    // Next divider count and the clock level it implies.
    always_comb begin
        div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + 1'b1;
        ssp_clk_d = (div_cnt_d >= HALF);
    end

    // Edge strobes: wrap to 0 is the falling edge, step to HALF the rising one.
    always_comb begin
        strb      = '0;
        strb.fall = (div_cnt_q == LAST);
        strb.rise = (div_cnt_q == RISE_AT);
    end

    // Divider and clock registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            ssp_clk_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            ssp_clk_q <= ssp_clk_d;
        end
    end

    assign ssp_clk = ssp_clk_q;

endmodule

// File: rtl/ssp_link.sv
// SSP link: continuous framed word exchange with the ARM.
// TX: one-word holding register feeds a shifter loaded at every word start;
//     an empty holding register sends the idle word, still framed.
// RX: bits sampled on ssp_clk rising edges, word presented with a one-cycle
//     rx_valid pulse (no backpressure).
// Optional build macro SSP_LINK_LOOPBACK_EN: RX samples the outgoing
// ssp_din instead of ssp_dout.
module ssp_link
    import ssp_link_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int WORD_BITS = DEF_WORD_BITS
) (
    input  logic                 ck_1356meg,
    input  logic                 rst,
    input  logic [WORD_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [WORD_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 ssp_clk,
    output logic                 ssp_frame,
    output logic                 ssp_din,
    input  logic                 ssp_dout
);

    localparam int                   BW       = $clog2(WORD_BITS);
    localparam logic [BW-1:0]        LAST_BIT = BW'(WORD_BITS - 1);
    localparam logic [WORD_BITS-1:0] IDLE     = WORD_BITS'(IDLE_WORD);

    ssp_edge_t strb;

    ssp_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk     (ck_1356meg),
        .rst     (rst),
        .ssp_clk (ssp_clk),
        .strb    (strb)
    );

    // bit_idx_q is the index of the bit that starts at the next falling edge.
    logic [BW-1:0]        bit_idx_q,   bit_idx_d;
    logic                 started_q,   started_d;
    logic                 hold_full_q, hold_full_d;
    logic [WORD_BITS-1:0] hold_q,      hold_d;
    logic [WORD_BITS-1:0] tx_sh_q,     tx_sh_d;
    logic                 ssp_frame_q, ssp_frame_d;
    logic                 ssp_din_q,   ssp_din_d;
    logic [WORD_BITS-1:0] rx_sh_q,     rx_sh_d;
    logic                 rx_done_q,   rx_done_d;
    logic                 rx_valid_q,  rx_valid_d;
    logic [WORD_BITS-1:0] rx_data_q,   rx_data_d;

    logic                 hs;
    logic [WORD_BITS-1:0] out_word;
    logic                 rx_in;

    assign hs       = tx_valid & ~hold_full_q;
    assign out_word = hold_full_q ? hold_q : IDLE;

`ifdef SSP_LINK_LOOPBACK_EN
    logic unused_ssp_dout;
    assign unused_ssp_dout = ssp_dout;
    assign rx_in           = ssp_din_q;
`else
    assign rx_in = ssp_dout;
`endif

    // Framing, TX load/shift and the holding-register handshake.
    always_comb begin
        bit_idx_d   = bit_idx_q;
        started_d   = started_q;
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        tx_sh_d     = tx_sh_q;
        ssp_frame_d = ssp_frame_q;
        ssp_din_d   = ssp_din_q;
        if (strb.fall) begin
            bit_idx_d = (bit_idx_q == LAST_BIT) ? '0 : bit_idx_q + 1'b1;
            started_d = 1'b1;
            if (bit_idx_q == '0) begin
                // Word start: take the held word (or idle) and frame it.
                tx_sh_d     = {out_word[WORD_BITS-2:0], 1'b0};
                ssp_din_d   = out_word[WORD_BITS-1];
                ssp_frame_d = 1'b1;
                hold_full_d = 1'b0;
            end else begin
                tx_sh_d     = {tx_sh_q[WORD_BITS-2:0], 1'b0};
                ssp_din_d   = tx_sh_q[WORD_BITS-1];
                ssp_frame_d = 1'b0;
            end
        end
        // A handshake in the load cycle refills the holding register after
        // the old content has gone to the shifter.
        if (hs) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    // RX shift on rising edges; a word completes on the rise of its last bit,
    // which is when bit_idx has already wrapped back to 0.
    always_comb begin
        rx_sh_d    = rx_sh_q;
        rx_done_d  = 1'b0;
        rx_valid_d = rx_done_q;
        rx_data_d  = rx_done_q ? rx_sh_q : rx_data_q;
        if (strb.rise) begin
            rx_sh_d   = {rx_sh_q[WORD_BITS-2:0], rx_in};
            rx_done_d = started_q & (bit_idx_q == '0);
        end
    end

    // Link state registers.
    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            bit_idx_q   <= '0;
            started_q   <= 1'b0;
            hold_full_q <= 1'b0;
            hold_q      <= '0;
            tx_sh_q     <= '0;
            ssp_frame_q <= 1'b0;
            ssp_din_q   <= 1'b0;
            rx_sh_q     <= '0;
            rx_done_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
        end else begin
            bit_idx_q   <= bit_idx_d;
            started_q   <= started_d;
            hold_full_q <= hold_full_d;
            hold_q      <= hold_d;
            tx_sh_q     <= tx_sh_d;
            ssp_frame_q <= ssp_frame_d;
            ssp_din_q   <= ssp_din_d;
            rx_sh_q     <= rx_sh_d;
            rx_done_q   <= rx_done_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
        end
    end

    assign tx_ready  = ~hold_full_q;
    assign ssp_frame = ssp_frame_q;
    assign ssp_din   = ssp_din_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;

endmodule
